// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UART PISO serializer from NUM_REQ clients.
// The winner's word is captured and sent with a one-cycle load strobe. No further load is issued until the frame and the inter-frame gap have completed.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 5,
  parameter int GAP     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DEPTH-1:0]   data_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       uart_enable,
  output logic [DEPTH-1:0]           uart_data_in
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(((DEPTH > GAP) ? DEPTH : GAP) + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(DEPTH);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic            any_req;
  logic [DEPTH-1:0] win_word;

  // Scan from the highest offset down, so the nearest requester after ptr is the last one written and wins.
  always_comb begin
    logic [PW-1:0] cand;
    win     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = PW'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        win     = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PW'(i)) win_word = data_in[i*DEPTH +: DEPTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ptr          <= PW'(NUM_REQ - 1);
      gnt          <= '0;
      owner        <= '0;
      busy         <= 1'b0;
      uart_enable  <= 1'b0;
      uart_data_in <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state        <= S_LOAD;
            ptr          <= win;
            owner        <= win;
            uart_data_in <= win_word;
            gnt          <= NUM_REQ'(1) << win;
            uart_enable  <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_LOAD: begin
          state       <= S_SHIFT;
          cnt         <= '0;
          gnt         <= '0;
          uart_enable <= 1'b0;
        end
        S_SHIFT: begin
          // DEPTH data bits plus the stop bit: counter values 0..DEPTH.
          if (cnt == SHIFT_LAST) begin
            cnt <= '0;
            if (GAP == 0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a default build with GAP=1 and a second build with GAP=0.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req2;
  logic [19:0] data, data2;
  logic [3:0]  gnt, gnt2;
  logic [1:0]  owner, owner2;
  logic        busy, busy2, en, en2;
  logic [4:0]  dat, dat2;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .DEPTH(5), .GAP(1)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data),
    .gnt(gnt), .owner(owner), .busy(busy),
    .uart_enable(en), .uart_data_in(dat)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DEPTH(5), .GAP(0)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .data_in(data2),
    .gnt(gnt2), .owner(owner2), .busy(busy2),
    .uart_enable(en2), .uart_data_in(dat2)
  );

  typedef struct {
    logic [3:0] g;
    logic [1:0] o;
    logic [4:0] d;
    int         per;   // expected cycles since previous load, 0 = unchecked
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last1    = 0;
  int   last2    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] o, input logic [4:0] d, input int per);
    exp_t e;
    e.g = g; e.o = o; e.d = d; e.per = per;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_with_enable", int'(gnt != 4'b0), int'(en));
      if (en) begin
        if (q1.size() == 0) begin
          chk("unexpected_load", 1, 0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("gnt", int'(gnt), int'(e.g));
          chk("owner", int'(owner), int'(e.o));
          chk("data", int'(dat), int'(e.d));
          if (e.per != 0) chk("load_period", cyc - last1, e.per);
        end
        last1 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("gap0_gnt_with_enable", int'(gnt2 != 4'b0), int'(en2));
      if (en2) begin
        if (q2.size() == 0) begin
          chk("gap0_unexpected_load", 1, 0);
        end else begin
          exp_t e;
          e = q2.pop_front();
          chk("gap0_gnt", int'(gnt2), int'(e.g));
          chk("gap0_owner", int'(owner2), int'(e.o));
          chk("gap0_data", int'(dat2), int'(e.d));
          if (e.per != 0) chk("gap0_load_period", cyc - last2, e.per);
        end
        last2 = cyc;
      end
    end
  end

  // Returns at the negedge where the load strobe is seen; n = extra negedges waited.
  task automatic wait_en(input int which, output int n);
    n = 0;
    @(negedge clk);
    while (((which == 1) ? !en : !en2) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if ((which == 1) ? !en : !en2) chk("load_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; req2 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    rst = 1'b1; req = '0; req2 = '0; data = '0; data2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_enable", int'(en), 0);
    chk("rst_data", int'(dat), 0);

    // Single request: one-cycle latency, busy for 1+6+1 cycles.
    data[5 +: 5] = 5'h15;
    q1.push_back(mk(4'b0010, 2'd1, 5'h15, 0));
    req = 4'b0010;
    wait_en(1, n);
    chk("single_latency", n, 0);
    req = '0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("single_busy_len", n, 8);

    // All requesting: 0,1,2,3,0 spaced 9 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) data[i*5 +: 5] = 5'(5'h10 + i);
    q1.push_back(mk(4'b0001, 2'd0, 5'h10, 0));
    q1.push_back(mk(4'b0010, 2'd1, 5'h11, 9));
    q1.push_back(mk(4'b0100, 2'd2, 5'h12, 9));
    q1.push_back(mk(4'b1000, 2'd3, 5'h13, 9));
    q1.push_back(mk(4'b0001, 2'd0, 5'h10, 9));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_en(1, n);
    req = '0;
    repeat (10) @(negedge clk);

    // Two requesters alternate; req1 raised in SHIFT after a grant to 2 still loses to 0.
    do_reset();
    data[0 +: 5] = 5'h01; data[5 +: 5] = 5'h0A; data[10 +: 5] = 5'h1C;
    q1.push_back(mk(4'b0001, 2'd0, 5'h01, 0));
    q1.push_back(mk(4'b0100, 2'd2, 5'h1C, 9));
    q1.push_back(mk(4'b0001, 2'd0, 5'h01, 9));
    q1.push_back(mk(4'b0100, 2'd2, 5'h1C, 9));
    q1.push_back(mk(4'b0001, 2'd0, 5'h01, 9));
    q1.push_back(mk(4'b0010, 2'd1, 5'h0A, 9));
    req = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      wait_en(1, n);
      if (k == 3) begin
        repeat (2) @(negedge clk);
        req = 4'b0111;
      end
      if (k == 5) req = '0;
    end
    repeat (10) @(negedge clk);

    // Late request during SHIFT waits for IDLE; captured word survives data_in changes.
    do_reset();
    data[0 +: 5] = 5'h11;
    q1.push_back(mk(4'b0001, 2'd0, 5'h11, 0));
    req = 4'b0001;
    wait_en(1, n);
    req = '0;
    q1.push_back(mk(4'b1000, 2'd3, 5'h07, 9));
    repeat (3) @(negedge clk);
    data[15 +: 5] = 5'h07;
    req = 4'b1000;
    wait_en(1, n);
    req = '0;
    data[15 +: 5] = 5'h1F;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (dat !== 5'h07) ok = 1'b0;
    end
    chk("late_data_held", int'(ok), 1);

    // Asynchronous reset mid-frame, then a fresh arbitration.
    do_reset();
    data[0 +: 5] = 5'h12;
    q1.push_back(mk(4'b0001, 2'd0, 5'h12, 0));
    req = 4'b0001;
    wait_en(1, n);
    req = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_gnt", int'(gnt), 0);
    chk("arst_enable", int'(en), 0);
    chk("arst_data", int'(dat), 0);
    chk("arst_owner", int'(owner), 0);
    data[15 +: 5] = 5'h0B;
    q1.push_back(mk(4'b1000, 2'd3, 5'h0B, 0));
    req = 4'b1000;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_en(1, n);
    chk("post_rst_latency", n, 1);
    req = '0;
    repeat (10) @(negedge clk);

    // GAP=0 build: loads 8 cycles apart, busy for 1+6 cycles.
    do_reset();
    data2[0 +: 5] = 5'h03; data2[5 +: 5] = 5'h1D;
    q2.push_back(mk(4'b0001, 2'd0, 5'h03, 0));
    q2.push_back(mk(4'b0010, 2'd1, 5'h1D, 8));
    q2.push_back(mk(4'b0001, 2'd0, 5'h03, 8));
    q2.push_back(mk(4'b0010, 2'd1, 5'h1D, 8));
    req2 = 4'b0011;
    wait_en(2, n);
    n = 0;
    while (busy2 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("gap0_busy_len", n, 7);
    for (int k = 0; k < 3; k++) wait_en(2, n);
    req2 = '0;
    repeat (10) @(negedge clk);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler sharing one UART transmit serializer (PISO, parallel load on `enable`, shift while `enable` low) among NUM_REQ requesters.
- Arbitrates, captures the winner's word, and issues a one-cycle load pulse plus data to the serializer.
- Holds off further loads until that frame has shifted out (DEPTH data bits plus stop) and an inter-frame gap has elapsed.
- Sits between the client blocks and the serializer's `enable`/`data_in` port.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- DEPTH, 5, data bits per frame; must match serializer width (>=2)
- GAP, 1, idle-line cycles inserted after each frame (>=0; 0 skips GAP state)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester transmit request, level
- data_in  input  NUM_REQ*DEPTH  packed words; requester i uses bits [i*DEPTH +: DEPTH]
- gnt  output  NUM_REQ  one-hot, one-cycle pulse to the requester whose word is loaded
- owner  output  $clog2(NUM_REQ)  index of last granted requester
- busy  output  1  high while a frame is loading, shifting or in gap
- uart_enable  output  1  one-cycle load strobe to serializer
- uart_data_in  output  DEPTH  word to serializer

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, gnt=0, owner=0, busy=0, uart_enable=0, uart_data_in=0, counter=0, RR pointer=NUM_REQ-1 (so requester 0 wins first).
- Reset mid-frame: all outputs take their reset values immediately and asynchronously; no load pulse after release until a new arbitration.
- All outputs are registered.
- State machine IDLE -> LOAD -> SHIFT -> GAP -> IDLE:
  - IDLE: busy=0. If any req bit is high, pick the winner by round-robin and go to LOAD. The search starts at pointer+1 mod NUM_REQ, ascending with wrap. At the same edge, capture the winner's data_in word and update pointer and owner.
  - LOAD: exactly 1 cycle. uart_enable=1, gnt[winner]=1, busy=1; uart_data_in holds the captured word. Next state is SHIFT with counter=0.
  - SHIFT: uart_enable=0, gnt=0, busy=1. Counter increments each cycle; after DEPTH+1 cycles (DEPTH data bits plus stop), go to GAP, or to IDLE if GAP=0.
  - GAP: busy=1 for GAP cycles, then IDLE.
- Latency: req sampled high in IDLE at cycle T -> uart_enable and gnt high in cycle T+1.
- Frame spacing: minimum period between uart_enable pulses is DEPTH+GAP+3 cycles (9 at defaults).
- Data capture: uart_data_in holds the captured word from arbitration until the next arbitration. Changes to data_in or req after capture do not affect the frame in flight.
- Request handshake:
  - A requester holds req and its word until it sees gnt.
  - req dropped before arbitration: that requester is not considered.
  - req dropped during LOAD/SHIFT/GAP: no effect on the current frame.
- Requests arriving while busy=1 are ignored until IDLE; there is no queuing inside the block.
- Simultaneous requests: exactly one grant per frame. A requester holding req continuously is served within NUM_REQ frames.
- gnt and uart_enable are always asserted together in the same cycle, never otherwise.

Test Plan:
1. Single request: rst released, req=4'b0010, word1=5'h15 -> next cycle uart_enable=1, gnt=4'b0010, uart_data_in=5'h15, owner=1. busy stays high 8 cycles (1+6+1), then low.
2. All requests held: req=4'b1111 continuously -> grants in order 0,1,2,3,0, with uart_enable pulses exactly 9 cycles apart.
3. Fairness with two requesters: req=4'b0101 held -> grants alternate 0,2,0,2; after gnt to 2, next gnt goes to 0 even if req1 is raised during that frame's SHIFT.
4. Late request: req0 granted; req3 raised in 3rd SHIFT cycle -> no gnt until IDLE; gnt[3] arrives 9 cycles after gnt[0]. Word3 changed after capture -> uart_data_in keeps the captured value through the frame.
5. Reset mid-frame: rst pulsed during SHIFT -> busy, gnt, uart_enable and uart_data_in go to 0 without waiting for a clock edge. After release with req=4'b1000 -> gnt=4'b1000, owner=3 on the cycle after the first sampling edge.
6. GAP=0 build: req=4'b0011 held -> uart_enable pulses 8 cycles apart; GAP state never entered.
